systolic_feed_ctrl: RTL

Sequencer for an NxN systolic matrix-multiply tile. It drives the per-row operand muxes (A side) and per-column operand muxes (B side) with the diagonal skew the array needs. It also clears the PE accumulators, waits out the array pipeline latency, then steps the result read-out row by row. It replaces the fixed free-running mux-reset controller with a start/done-handshaked, stallable, parameterised scheduler.

---
 rtl/systolic_feed_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - start/done handshaked, stallable operand-skew and read-out sequencer for an NxN systolic tile
module systolic_feed_ctrl #(
    parameter int N      = 2,
    parameter int PE_LAT = 1,
    parameter int SELW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    output logic                busy,
    output logic                done,
    output logic                acc_clr,
    output logic [N-1:0]        row_en,
    output logic [N*SELW-1:0]   row_sel,
    output logic [N-1:0]        col_en,
    output logic [N*SELW-1:0]   col_sel,
    output logic                out_valid,
    output logic [SELW-1:0]     out_row
);

    // One shared step counter; it must reach the longest phase without wrapping.
    localparam int CMAX = (2 * N - 2 > PE_LAT - 1) ? 2 * N - 2 : PE_LAT - 1;
    localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            stall_q;
    logic [N-1:0]    feed_en;

    // Stall is registered so no input reaches an output combinationally; the
    // frozen step is replayed once stall_q drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            stall_q <= stall;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                if (!stall_q) begin
                    state_nx = FEED;
                    cnt_nx   = '0;
                end
            end
            FEED: begin
                if (!stall_q) begin
                    if (cnt == CW'(2 * N - 2)) begin
                        state_nx = DRAIN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!stall_q) begin
                    if (cnt == CW'(PE_LAT - 1)) begin
                        state_nx = OUT;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            OUT: begin
                if (!stall_q) begin
                    if (cnt == CW'(N - 1)) begin
                        state_nx = DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        acc_clr   = (state == CLEAR) && !stall_q;
        out_valid = (state == OUT) && !stall_q;
        out_row   = (state == OUT) ? SELW'(cnt) : '0;
        feed_en   = '0;
        row_sel   = '0;
        // Row/column k sees element t-k during the N-step window starting at t=k.
        for (int i = 0; i < N; i++) begin
            if (state == FEED && int'(cnt) >= i && int'(cnt) < i + N) begin
                feed_en[i]                = 1'b1;
                row_sel[i*SELW +: SELW]   = SELW'(int'(cnt) - i);
            end
        end
        row_en  = stall_q ? '0 : feed_en;
        col_en  = row_en;
        col_sel = row_sel;
    end

endmodule
